// File: rtl/chn_arb_rr.sv
// rtl/chn_arb_rr.sv - channel-local requester arbiter with grant watchdog and TRN tx mux
module chn_arb_rr #(
  parameter int NREQ = 3,
  parameter int MODE = 0,
  parameter int TMO  = 256,
  parameter int TMOW = 16
) (
  input  logic              pcie_clk,
  input  logic              pcie_rst,
  input  logic              chn_trn,
  output logic              chn_reqep,
  output logic              chn_drvn,
  input  logic [NREQ-1:0]   req_ep,
  input  logic [NREQ-1:0]   drv_ep,
  output logic [NREQ-1:0]   my_trn,
  input  logic [NREQ*64-1:0] req_td,
  input  logic [NREQ*8-1:0] req_trem_n,
  input  logic [NREQ-1:0]   req_tsof_n,
  input  logic [NREQ-1:0]   req_teof_n,
  input  logic [NREQ-1:0]   req_tsrc_rdy_n,
  output logic [63:0]       trn_td,
  output logic [7:0]        trn_trem_n,
  output logic              trn_tsof_n,
  output logic              trn_teof_n,
  output logic              trn_tsrc_rdy_n,
  output logic [TMOW-1:0]   tmo_cnt
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TMO);

  typedef enum logic [2:0] {IDLE, WAIT_UP, GRANT, BUSY, REL} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   g, g_nxt, last, last_nxt, winner;
  logic [WW-1:0]   wdog, wdog_nxt;
  logic [TMOW-1:0] tmo_nxt;
  logic            active;

  // Winner selection: rotating search after the previous grant, or lowest index.
  always_comb begin
    int            idx;
    logic [GW-1:0] idx_g;
    logic          found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    idx_g  = '0;
    if (MODE == 1) begin
      for (int i = NREQ-1; i >= 0; i--)
        if (req_ep[i]) winner = GW'(i);
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        idx   = (int'(last) + k) % NREQ;
        idx_g = GW'(idx);
        if (!found && req_ep[idx_g]) begin
          winner = idx_g;
          found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    last_nxt  = last;
    wdog_nxt  = wdog;
    tmo_nxt   = tmo_cnt;
    case (state)
      IDLE: begin
        if (|req_ep) begin
          g_nxt     = winner;
          state_nxt = WAIT_UP;
        end
      end
      WAIT_UP: begin
        if (chn_trn) begin
          state_nxt = GRANT;
          wdog_nxt  = '0;
        end else if (!req_ep[g]) begin
          state_nxt = REL;
        end
      end
      GRANT: begin
        if (drv_ep[g]) begin
          state_nxt = BUSY;
        end else if (!req_ep[g]) begin
          state_nxt = REL;
        end else if (wdog == WW'(TMO-1)) begin
          state_nxt = REL;
          if (tmo_cnt != '1) tmo_nxt = tmo_cnt + TMOW'(1);
        end else begin
          wdog_nxt = wdog + WW'(1);
        end
      end
      BUSY: begin
        if (!drv_ep[g]) state_nxt = REL;
      end
      REL: begin
        last_nxt  = g;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) begin
      state   <= IDLE;
      g       <= '0;
      last    <= GW'(NREQ-1);
      wdog    <= '0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      g       <= g_nxt;
      last    <= last_nxt;
      wdog    <= wdog_nxt;
      tmo_cnt <= tmo_nxt;
    end
  end

  // Grant is gated by the live upstream grant so a revocation shows up immediately.
  assign active    = (state == GRANT) || (state == BUSY);
  assign chn_reqep = (state == WAIT_UP) || active;
  assign my_trn    = (active && chn_trn) ? (NREQ'(1) << g) : '0;
  assign chn_drvn  = active && drv_ep[g];

  always_comb begin
    trn_td         = 64'd0;
    trn_trem_n     = 8'hFF;
    trn_tsof_n     = 1'b1;
    trn_teof_n     = 1'b1;
    trn_tsrc_rdy_n = 1'b1;
    if (active) begin
      trn_td         = req_td[{g, 6'b0} +: 64];
      trn_trem_n     = req_trem_n[{g, 3'b0} +: 8];
      trn_tsof_n     = req_tsof_n[g];
      trn_teof_n     = req_teof_n[g];
      trn_tsrc_rdy_n = req_tsrc_rdy_n[g];
    end
  end

endmodule

// File: tb/tb_chn_arb_rr.sv
// tb/tb_chn_arb_rr.sv - self-checking bench: round-robin and fixed-priority instances against a behavioural model
module tb_chn_arb_rr;

  logic         clk;
  logic         rst;
  logic [2:0]   req_ep [2];
  logic [2:0]   drv_ep [2];
  logic         chn_trn [2];
  logic [191:0] req_td;
  logic [23:0]  req_trem_n;
  logic [2:0]   req_tsof_n, req_teof_n, req_tsrc_rdy_n;

  logic         chn_reqep [2];
  logic         chn_drvn [2];
  logic [2:0]   my_trn [2];
  logic [63:0]  trn_td [2];
  logic [7:0]   trn_trem_n [2];
  logic         trn_tsof_n [2];
  logic         trn_teof_n [2];
  logic         trn_tsrc_rdy_n [2];
  logic [15:0]  tmo_a;
  logic [1:0]   tmo_b;

  int n_chk = 0;
  int n_pass = 0;
  bit cmp_en = 0;

  // Unit 0: round-robin, full watchdog. Unit 1: fixed priority, short watchdog, 2-bit counter.
  chn_arb_rr #(.NREQ(3), .MODE(0), .TMO(256), .TMOW(16)) u_rr (
    .pcie_clk(clk), .pcie_rst(rst), .chn_trn(chn_trn[0]), .chn_reqep(chn_reqep[0]),
    .chn_drvn(chn_drvn[0]), .req_ep(req_ep[0]), .drv_ep(drv_ep[0]), .my_trn(my_trn[0]),
    .req_td(req_td), .req_trem_n(req_trem_n), .req_tsof_n(req_tsof_n),
    .req_teof_n(req_teof_n), .req_tsrc_rdy_n(req_tsrc_rdy_n), .trn_td(trn_td[0]),
    .trn_trem_n(trn_trem_n[0]), .trn_tsof_n(trn_tsof_n[0]), .trn_teof_n(trn_teof_n[0]),
    .trn_tsrc_rdy_n(trn_tsrc_rdy_n[0]), .tmo_cnt(tmo_a));

  chn_arb_rr #(.NREQ(3), .MODE(1), .TMO(8), .TMOW(2)) u_fp (
    .pcie_clk(clk), .pcie_rst(rst), .chn_trn(chn_trn[1]), .chn_reqep(chn_reqep[1]),
    .chn_drvn(chn_drvn[1]), .req_ep(req_ep[1]), .drv_ep(drv_ep[1]), .my_trn(my_trn[1]),
    .req_td(req_td), .req_trem_n(req_trem_n), .req_tsof_n(req_tsof_n),
    .req_teof_n(req_teof_n), .req_tsrc_rdy_n(req_tsrc_rdy_n), .trn_td(trn_td[1]),
    .trn_trem_n(trn_trem_n[1]), .trn_tsof_n(trn_tsof_n[1]), .trn_teof_n(trn_teof_n[1]),
    .trn_tsrc_rdy_n(trn_tsrc_rdy_n[1]), .tmo_cnt(tmo_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model phases: 0 idle, 1 waiting for upstream, 2 granted, 3 driving, 4 release gap.
  int m_mode [2] = '{0, 1};
  int m_tmo  [2] = '{256, 8};
  int m_max  [2] = '{65535, 3};
  int ph [2], mg [2], mlast [2], mage [2], mtmo [2];

  function automatic int pick(input int m, input logic [2:0] r);
    if (m_mode[m] == 1) begin
      for (int i = 0; i < 3; i++) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= 3; k++) begin
        int j;
        j = (mlast[m] + k) % 3;
        if (r[j]) return j;
      end
    end
    return 0;
  endfunction

  function automatic int idx_of(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        ph[m] = 0; mg[m] = 0; mlast[m] = 2; mage[m] = 0; mtmo[m] = 0;
      end else begin
        case (ph[m])
          0: if (req_ep[m] != 0) begin mg[m] = pick(m, req_ep[m]); ph[m] = 1; end
          1: if (chn_trn[m]) begin ph[m] = 2; mage[m] = 1; end
             else if (!req_ep[m][mg[m]]) ph[m] = 4;
          2: if (drv_ep[m][mg[m]]) ph[m] = 3;
             else if (!req_ep[m][mg[m]]) ph[m] = 4;
             else if (mage[m] >= m_tmo[m]) begin
               ph[m] = 4;
               if (mtmo[m] < m_max[m]) mtmo[m] = mtmo[m] + 1;
             end else mage[m] = mage[m] + 1;
          3: if (!drv_ep[m][mg[m]]) ph[m] = 4;
          default: begin mlast[m] = mg[m]; ph[m] = 0; end
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int m = 0; m < 2; m++) begin
        bit          on;
        logic [63:0] e_td;
        logic [7:0]  e_trem;
        logic        e_sof, e_eof, e_rdy;
        logic [15:0] t_act;
        on     = (ph[m] == 2) || (ph[m] == 3);
        e_td   = on ? req_td[mg[m]*64 +: 64] : 64'd0;
        e_trem = on ? req_trem_n[mg[m]*8 +: 8] : 8'hFF;
        e_sof  = on ? req_tsof_n[mg[m]] : 1'b1;
        e_eof  = on ? req_teof_n[mg[m]] : 1'b1;
        e_rdy  = on ? req_tsrc_rdy_n[mg[m]] : 1'b1;
        t_act  = (m == 0) ? tmo_a : {14'd0, tmo_b};
        chk($sformatf("u%0d.chn_reqep", m), 64'(chn_reqep[m]), 64'(ph[m] >= 1 && ph[m] <= 3));
        chk($sformatf("u%0d.my_trn", m), 64'(my_trn[m]), (on && chn_trn[m]) ? (64'd1 << mg[m]) : 64'd0);
        chk($sformatf("u%0d.chn_drvn", m), 64'(chn_drvn[m]), 64'(on && drv_ep[m][mg[m]]));
        chk($sformatf("u%0d.trn_td", m), trn_td[m], e_td);
        chk($sformatf("u%0d.trn_trem_n", m), 64'(trn_trem_n[m]), 64'(e_trem));
        chk($sformatf("u%0d.trn_framing", m),
            64'({trn_tsof_n[m], trn_teof_n[m], trn_tsrc_rdy_n[m]}), 64'({e_sof, e_eof, e_rdy}));
        chk($sformatf("u%0d.tmo_cnt", m), 64'(t_act), 64'(mtmo[m]));
      end
    end
  end

  int gq[$];
  int gapq[$];
  bit oh_ok;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Requester emulation: the granted requester drives for 'hold' cycles, then drops.
  task automatic run_drv(input int m, input int hold, input int ncyc);
    int held, zc;
    logic [2:0] prev;
    held = 0; zc = 0; prev = 3'b000;
    gq.delete(); gapq.delete(); oh_ok = 1;
    for (int c = 0; c < ncyc; c++) begin
      step();
      if (!$onehot0(my_trn[m])) oh_ok = 0;
      if (drv_ep[m] != 0) begin
        held++;
        if (held >= hold) drv_ep[m] = 3'b000;
      end else if (my_trn[m] != 0 && prev == 0) begin
        if (gq.size() > 0) gapq.push_back(zc);
        gq.push_back(idx_of(my_trn[m]));
        drv_ep[m] = my_trn[m];
        held = 0;
      end
      if (my_trn[m] == 0) zc++;
      else zc = 0;
      prev = my_trn[m];
    end
  endtask

  task automatic wait_grant(input int m, input int lim, output int idx);
    bit done;
    idx = -1; done = 0;
    for (int c = 0; c < lim && !done; c++) begin
      step();
      if (my_trn[m] != 0) begin idx = idx_of(my_trn[m]); done = 1; end
    end
  endtask

  task automatic quiesce();
    for (int m = 0; m < 2; m++) begin req_ep[m] = 0; drv_ep[m] = 0; chn_trn[m] = 0; end
    repeat (6) step();
  endtask

  task automatic rand_data();
    for (int i = 0; i < 6; i++) req_td[i*32 +: 32] = $urandom();
    req_trem_n     = 24'($urandom());
    req_tsof_n     = 3'($urandom());
    req_teof_n     = 3'($urandom());
    req_tsrc_rdy_n = 3'($urandom());
  endtask

  initial begin
    int idx, hi;
    bit flag;
    rst = 1;
    for (int m = 0; m < 2; m++) begin req_ep[m] = 0; drv_ep[m] = 0; chn_trn[m] = 0; end
    rand_data();
    step();
    step();
    rst = 0;
    cmp_en = 1;
    chk("reset.my_trn", 64'(my_trn[0]), 64'd0);
    chk("reset.chn_reqep", 64'(chn_reqep[0]), 64'd0);
    chk("reset.trn_trem_n", 64'(trn_trem_n[0]), 64'hFF);
    chk("reset.tmo_cnt", 64'(tmo_a), 64'd0);

    // Round-robin rotation with all three requesting.
    req_ep[0] = 3'b111; chn_trn[0] = 1;
    run_drv(0, 4, 32);
    chk("rr.count", 64'(gq.size()), 64'd4);
    if (gq.size() >= 4) begin
      chk("rr.g0", 64'(gq[0]), 64'd0);
      chk("rr.g1", 64'(gq[1]), 64'd1);
      chk("rr.g2", 64'(gq[2]), 64'd2);
      chk("rr.g3", 64'(gq[3]), 64'd0);
    end
    foreach (gapq[i]) chk($sformatf("rr.gap%0d", i), 64'(gapq[i]), 64'd3);
    chk("rr.onehot", 64'(oh_ok), 64'd1);
    quiesce();

    // Fixed priority: requester 1 keeps winning over 2.
    req_ep[1] = 3'b110; chn_trn[1] = 1;
    run_drv(1, 2, 30);
    chk("fp.enough_grants", 64'(gq.size() >= 3), 64'd1);
    flag = 1;
    foreach (gq[i]) if (gq[i] != 1) flag = 0;
    chk("fp.always_1", 64'(flag), 64'd1);
    quiesce();

    // Watchdog: requester 2 never drives.
    req_ep[0] = 3'b100; chn_trn[0] = 1;
    wait_grant(0, 10, idx);
    chk("tmo.grant_idx", 64'(idx), 64'd2);
    hi = (idx == 2) ? 1 : 0;
    for (int c = 0; c < 300 && my_trn[0][2]; c++) begin
      step();
      if (my_trn[0][2]) hi++;
    end
    chk("tmo.grant_cycles", 64'(hi), 64'd256);
    chk("tmo.cnt", 64'(tmo_a), 64'd1);
    chk("tmo.model_cnt", 64'(mtmo[0]), 64'd1);
    chk("tmo.rel_reqep", 64'(chn_reqep[0]), 64'd0);
    req_ep[0] = 3'b101;
    wait_grant(0, 10, idx);
    chk("tmo.next_winner", 64'(idx), 64'd0);
    quiesce();

    // Upstream holds off the grant.
    req_ep[0] = 3'b001; chn_trn[0] = 0;
    flag = 1;
    for (int c = 0; c < 50; c++) begin
      step();
      if (chn_reqep[0] !== 1'b1 || my_trn[0] !== 3'b000 || trn_tsrc_rdy_n[0] !== 1'b1) flag = 0;
    end
    chk("hold.waiting", 64'(flag), 64'd1);
    chn_trn[0] = 1;
    #1;
    chk("hold.no_same_cycle", 64'(my_trn[0]), 64'd0);
    step();
    chk("hold.grant", 64'(my_trn[0]), 64'd1);
    quiesce();

    // Mux selects requester 1 exactly, idle values around it.
    req_td[63:0] = {$urandom(), $urandom()};
    req_td[127:64] = 64'hDEADBEEF_0000_0001;
    req_trem_n[15:8] = 8'h0F;
    req_tsof_n = 3'b100; req_tsrc_rdy_n = 3'b100;
    req_ep[0] = 3'b010; chn_trn[0] = 1;
    #1;
    chk("mux.pre_td", trn_td[0], 64'd0);
    step();
    chk("mux.wait_sof", 64'(trn_tsof_n[0]), 64'd1);
    step();
    chk("mux.grant_td", trn_td[0], 64'hDEADBEEF_0000_0001);
    chk("mux.grant_sof", 64'(trn_tsof_n[0]), 64'd0);
    chk("mux.grant_trem", 64'(trn_trem_n[0]), 64'h0F);
    drv_ep[0] = 3'b010;
    step();
    chk("mux.busy_td", trn_td[0], 64'hDEADBEEF_0000_0001);
    drv_ep[0] = 3'b000;
    step();
    chk("mux.rel_td", trn_td[0], 64'd0);
    chk("mux.rel_sof", 64'(trn_tsof_n[0]), 64'd1);
    quiesce();
    rand_data();

    // Reset while driving.
    req_ep[0] = 3'b010; chn_trn[0] = 1;
    wait_grant(0, 10, idx);
    chk("rst.pre_grant", 64'(idx), 64'd1);
    drv_ep[0] = 3'b010;
    step();
    rst = 1;
    step();
    chk("rst.my_trn", 64'(my_trn[0]), 64'd0);
    chk("rst.chn_reqep", 64'(chn_reqep[0]), 64'd0);
    chk("rst.chn_drvn", 64'(chn_drvn[0]), 64'd0);
    chk("rst.trn_td", trn_td[0], 64'd0);
    chk("rst.tmo_cnt", 64'(tmo_a), 64'd0);
    rst = 0; drv_ep[0] = 0; req_ep[0] = 3'b111;
    wait_grant(0, 10, idx);
    chk("rst.first_grant", 64'(idx), 64'd0);
    quiesce();

    // Randomised traffic on both units.
    for (int c = 0; c < 3000; c++) begin
      step();
      rst = ($urandom_range(0, 599) == 0);
      for (int m = 0; m < 2; m++) begin
        for (int b = 0; b < 3; b++) begin
          if ($urandom_range(0, 7) == 0) req_ep[m][b] = ~req_ep[m][b];
          if ($urandom_range(0, 3) == 0) drv_ep[m][b] = ~drv_ep[m][b];
        end
        chn_trn[m] = ($urandom_range(0, 3) != 0);
      end
      rand_data();
    end
    rst = 0;
    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
